pc_unit_ctrl: RTL and testbench

//  Parametrised fetch-stage program counter for the pipelined MIPS core; next generation of the IF PC register.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/pc_unit_ctrl_if.sv | 29 ++
 rtl/pc_addr_check.sv | 15 +
 rtl/pc_unit_ctrl.sv | 91 +++++++++
 tb/tb_pc_unit_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default fetch-stage vectors, memory window, PC step and
// PC-unit FSM state encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_VEC_DEF  = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF    = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_LIMIT_DEF = 32'h0000_4FFC;

  localparam int unsigned PC_STEP = 4;

  // Two-state fetch FSM, kept as plain constants for older tools.
  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StBrPend = 1'b1;

endpackage

// File: rtl/pc_unit_ctrl_if.sv
// Handshake bundle between the hazard unit / CP0 (master) and the fetch PC unit (slave).
interface pc_unit_ctrl_if #(
  parameter int unsigned W = 32
);

  logic         stall_i;
  logic         br_valid_i;
  logic [W-1:0] br_target_i;
  logic         exc_i;
  logic         irq_i;
  logic         eret_i;
  logic [W-1:0] epc_i;
  logic [W-1:0] pc_o;
  logic         adel_o;
  logic         redirect_o;
  logic         in_handler_o;
  logic         pend_o;

  modport master (
    output stall_i, br_valid_i, br_target_i, exc_i, irq_i, eret_i, epc_i,
    input  pc_o, adel_o, redirect_o, in_handler_o, pend_o
  );

  modport slave (
    input  stall_i, br_valid_i, br_target_i, exc_i, irq_i, eret_i, epc_i,
    output pc_o, adel_o, redirect_o, in_handler_o, pend_o
  );

endinterface

// File: rtl/pc_addr_check.sv
// Fetch address-error detect: misaligned or outside the instruction-memory window.
module pc_addr_check #(
  parameter int unsigned     W          = 32,
  parameter logic [W-1:0]    IMEM_BASE  = W'(cpu_pkg::IMEM_BASE_DEF),
  parameter logic [W-1:0]    IMEM_LIMIT = W'(cpu_pkg::IMEM_LIMIT_DEF)
) (
  input  logic [W-1:0] pc,
  output logic         adel
);

  always_comb begin
    adel = (pc[1:0] != 2'b00) | (pc < IMEM_BASE) | (pc > IMEM_LIMIT);
  end

endmodule

// File: rtl/pc_unit_ctrl.sv
// Fetch-stage program counter with exception/interrupt vectoring, ERET return,
// stall-deferred branch redirect and a registered flush pulse.
module pc_unit_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned  W          = 32,
  parameter logic [W-1:0] RESET_VEC  = W'(cpu_pkg::RESET_VEC_DEF),
  parameter logic [W-1:0] EXC_VEC    = W'(cpu_pkg::EXC_VEC_DEF),
  parameter logic [W-1:0] IMEM_BASE  = W'(cpu_pkg::IMEM_BASE_DEF),
  parameter logic [W-1:0] IMEM_LIMIT = W'(cpu_pkg::IMEM_LIMIT_DEF)
) (
  input  logic           clk,
  input  logic           reset,
  pc_unit_ctrl_if.slave  bus
);

  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pend_tgt_q, pend_tgt_d;
  logic [0:0]   state_q, state_d;
  logic         in_handler_q, in_handler_d;
  logic         redirect_q, redirect_d;
  logic         take_vec;

  // Interrupts are masked while a handler runs; exceptions never are.
  assign take_vec = bus.exc_i | (bus.irq_i & ~in_handler_q);

  always_comb begin
    pc_d         = pc_q + W'(PC_STEP);
    pend_tgt_d   = pend_tgt_q;
    state_d      = state_q;
    in_handler_d = in_handler_q;
    redirect_d   = 1'b0;
    if (take_vec) begin
      pc_d         = EXC_VEC;
      in_handler_d = 1'b1;
      state_d      = StRun;
      redirect_d   = 1'b1;
    end else if (bus.eret_i) begin
      pc_d         = bus.epc_i;
      in_handler_d = 1'b0;
      state_d      = StRun;
      redirect_d   = 1'b1;
    end else if (bus.stall_i) begin
      pc_d = pc_q;
      // Latest branch seen under stall wins.
      if (bus.br_valid_i) begin
        pend_tgt_d = bus.br_target_i;
        state_d    = StBrPend;
      end
    end else if (bus.br_valid_i) begin
      pc_d       = bus.br_target_i;
      state_d    = StRun;
      redirect_d = 1'b1;
    end else if (state_q == StBrPend) begin
      pc_d       = pend_tgt_q;
      state_d    = StRun;
      redirect_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VEC;
      pend_tgt_q   <= '0;
      state_q      <= StRun;
      in_handler_q <= 1'b0;
      redirect_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_tgt_q   <= pend_tgt_d;
      state_q      <= state_d;
      in_handler_q <= in_handler_d;
      redirect_q   <= redirect_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.redirect_o   = redirect_q;
  assign bus.in_handler_o = in_handler_q;
  assign bus.pend_o       = (state_q == StBrPend);

  pc_addr_check #(
    .W          (W),
    .IMEM_BASE  (IMEM_BASE),
    .IMEM_LIMIT (IMEM_LIMIT)
  ) u_addr_check (
    .pc   (pc_q),
    .adel (bus.adel_o)
  );

endmodule

// File: tb/tb_pc_unit_ctrl.sv
// Self-checking bench for pc_unit_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a behavioural fetch-PC model.
module tb_pc_unit_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  pc_unit_ctrl_if #(.W(32)) bus ();

  pc_unit_ctrl #(.W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  logic [31:0] m_pc, m_tgt;
  bit          m_inh, m_pend, m_redir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_adel(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < 32'h0000_3000) || (pc > 32'h0000_4FFC);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0000_3000; m_tgt = 0; m_inh = 0; m_pend = 0; m_redir = 0;
    end else if (bus.exc_i || (bus.irq_i && !m_inh)) begin
      m_pc = 32'h0000_4180; m_inh = 1; m_pend = 0; m_redir = 1;
    end else if (bus.eret_i) begin
      m_pc = bus.epc_i; m_inh = 0; m_pend = 0; m_redir = 1;
    end else if (bus.stall_i) begin
      m_redir = 0;
      if (bus.br_valid_i) begin
        m_tgt = bus.br_target_i; m_pend = 1;
      end
    end else if (bus.br_valid_i) begin
      m_pc = bus.br_target_i; m_pend = 0; m_redir = 1;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0; m_redir = 1;
    end else begin
      m_pc = m_pc + 32'd4; m_redir = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_o", bus.pc_o, m_pc);
      check("adel_o", 32'(bus.adel_o), 32'(model_adel(m_pc)));
      check("redirect_o", 32'(bus.redirect_o), 32'(m_redir));
      check("in_handler_o", 32'(bus.in_handler_o), 32'(m_inh));
      check("pend_o", 32'(bus.pend_o), 32'(m_pend));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0) a = $urandom;
    else a = 32'h0000_3000 + (32'($urandom_range(0, 32'h7FF)) << 2);
    return a;
  endfunction

  initial begin
    reset = 1'b1;
    bus.stall_i = 0; bus.br_valid_i = 0; bus.br_target_i = 0;
    bus.exc_i = 0; bus.irq_i = 0; bus.eret_i = 0; bus.epc_i = 0;
    tick();
    chk_en = 1'b1;
    tick();
    // 1: reset state and free run
    check("rst_pc", bus.pc_o, 32'h3000);
    check("rst_redirect", 32'(bus.redirect_o), 0);
    check("rst_in_handler", 32'(bus.in_handler_o), 0);
    check("rst_pend", 32'(bus.pend_o), 0);
    reset = 1'b0;
    tick(); check("run_pc1", bus.pc_o, 32'h3004);
    tick(); check("run_pc2", bus.pc_o, 32'h3008);
    tick(); check("run_pc3", bus.pc_o, 32'h300C);
    check("run_adel", 32'(bus.adel_o), 0);
    tick(); check("run_pc4", bus.pc_o, 32'h3010);

    // 2: branch deferred under stall
    bus.stall_i = 1; bus.br_valid_i = 1; bus.br_target_i = 32'h3400;
    tick(); check("stall_pc", bus.pc_o, 32'h3010);
    check("stall_pend", 32'(bus.pend_o), 1);
    bus.br_valid_i = 0;
    tick(); tick(); check("stall_hold", bus.pc_o, 32'h3010);
    bus.stall_i = 0;
    tick(); check("pend_pc", bus.pc_o, 32'h3400);
    check("pend_redirect", 32'(bus.redirect_o), 1);
    check("pend_clear", 32'(bus.pend_o), 0);
    tick(); check("pend_redirect_drop", 32'(bus.redirect_o), 0);

    // 3: interrupt, masking, ERET, immediate re-entry
    bus.br_valid_i = 1; bus.br_target_i = 32'h3020;
    tick(); bus.br_valid_i = 0;
    bus.irq_i = 1;
    tick(); check("irq_pc", bus.pc_o, 32'h4180);
    check("irq_inh", 32'(bus.in_handler_o), 1);
    tick(); check("irq_masked1", bus.pc_o, 32'h4184);
    tick(); check("irq_masked2", bus.pc_o, 32'h4188);
    bus.eret_i = 1; bus.epc_i = 32'h3020;
    tick(); check("eret_pc", bus.pc_o, 32'h3020);
    check("eret_inh", 32'(bus.in_handler_o), 0);
    bus.eret_i = 0;
    tick(); check("irq_again", bus.pc_o, 32'h4180);
    bus.irq_i = 0;

    // 4: exception beats stall and discards pending branch
    bus.stall_i = 1; bus.br_valid_i = 1; bus.br_target_i = 32'h3500;
    tick(); bus.br_valid_i = 0; bus.exc_i = 1;
    tick(); check("exc_pc", bus.pc_o, 32'h4180);
    check("exc_pend", 32'(bus.pend_o), 0);
    check("exc_redirect", 32'(bus.redirect_o), 1);
    bus.exc_i = 0; bus.stall_i = 0;
    tick(); check("exc_next", bus.pc_o, 32'h4184);

    // 5: address error boundaries and wrap
    bus.br_valid_i = 1; bus.br_target_i = 32'h3002;
    tick(); check("adel_mis", 32'(bus.adel_o), 1);
    bus.br_target_i = 32'h5000;
    tick(); check("adel_hi", 32'(bus.adel_o), 1);
    bus.br_target_i = 32'h4FFC;
    tick(); check("adel_lim", 32'(bus.adel_o), 0);
    bus.br_target_i = 32'hFFFF_FFFC;
    tick(); bus.br_valid_i = 0;
    tick(); check("wrap_pc", bus.pc_o, 32'h0);
    check("wrap_adel", 32'(bus.adel_o), 1);

    // 6: reset while pending inside handler
    bus.exc_i = 1;
    tick(); bus.exc_i = 0;
    bus.stall_i = 1; bus.br_valid_i = 1; bus.br_target_i = 32'h3600;
    tick(); reset = 1;
    tick(); check("rst2_pc", bus.pc_o, 32'h3000);
    check("rst2_pend", 32'(bus.pend_o), 0);
    check("rst2_inh", 32'(bus.in_handler_o), 0);
    check("rst2_redirect", 32'(bus.redirect_o), 0);
    reset = 0; bus.stall_i = 0; bus.br_valid_i = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      bus.exc_i      = ($urandom_range(0, 99) < 4);
      bus.irq_i      = ($urandom_range(0, 99) < 10);
      bus.eret_i     = ($urandom_range(0, 99) < 6);
      bus.stall_i    = ($urandom_range(0, 99) < 35);
      bus.br_valid_i = ($urandom_range(0, 99) < 25);
      bus.br_target_i = rand_addr();
      bus.epc_i       = rand_addr();
      tick();
    end
    reset = 0; bus.exc_i = 0; bus.irq_i = 0; bus.eret_i = 0;
    bus.stall_i = 0; bus.br_valid_i = 0;
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
